clock_divider_multi: RTL and testbench

CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

---
 rtl/clock_divider_multi.sv | 77 +++++++
 tb/tb_clock_divider_multi.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NCH independent programmable clock dividers with runtime divisor loads.
// Define CLKDIV_PHASE_SYNC_EN to add the sync input that realigns every channel phase.
module clock_divider_multi #(
    parameter int WIDTH       = 32,
    parameter int NCH         = 2,
    parameter int DEFAULT_DIV = 9000000
) (
    input  logic             clk,
    input  logic             reset,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic             sync,
`endif
    input  logic [NCH-1:0]   en,
    input  logic             load,
    input  logic [2:0]       load_ch,
    input  logic [WIDTH-1:0] load_val,
    output logic [NCH-1:0]   sclk,
    output logic [NCH-1:0]   tick,
    output logic             load_err
);
    logic [WIDTH-1:0] count_q [NCH];
    logic [WIDTH-1:0] count_d [NCH];
    logic [WIDTH-1:0] div_q   [NCH];
    logic [WIDTH-1:0] div_d   [NCH];
    logic [NCH-1:0]   sclk_q, sclk_d, tick_q, tick_d;
    logic             load_err_q, load_err_d;
    logic             load_ok;
    logic             sync_w;

`ifdef CLKDIV_PHASE_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    always_comb begin
        load_ok    = load && (32'(load_ch) < NCH);
        load_err_d = load && !load_ok && !sync_w;
        for (int i = 0; i < NCH; i++) begin
            count_d[i] = count_q[i];
            div_d[i]   = div_q[i];
            sclk_d[i]  = sclk_q[i];
            tick_d[i]  = 1'b0;
            if (sync_w) begin
                count_d[i] = '0;
                sclk_d[i]  = 1'b0;
            end else if (load_ok && load_ch == 3'(i)) begin
                div_d[i]   = load_val;
                count_d[i] = '0;
            end else if (en[i]) begin
                tick_d[i]  = count_q[i] == div_q[i];
                count_d[i] = tick_d[i] ? '0 : count_q[i] + WIDTH'(1);
                sclk_d[i]  = sclk_q[i] ^ tick_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '{default: '0};
            div_q      <= '{default: WIDTH'(DEFAULT_DIV)};
            sclk_q     <= '0;
            tick_q     <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign sclk     = sclk_q;
    assign tick     = tick_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed and random stimulus checked against a cycles-to-next-toggle model.
module tb_clock_divider_multi;
    localparam int WIDTH = 32;
    localparam int NCH   = 2;
    localparam int DDIV  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   en;
    logic             load;
    logic [2:0]       load_ch;
    logic [WIDTH-1:0] load_val;
    logic [NCH-1:0]   sclk, tick;
    logic             load_err;
`ifdef CLKDIV_PHASE_SYNC_EN
    logic             sync = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    longint           rem  [NCH];
    longint           mdiv [NCH];
    logic [NCH-1:0]   msclk, mtick;
    logic             merr;

    clock_divider_multi #(.WIDTH(WIDTH), .NCH(NCH), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk),
        .reset(reset),
`ifdef CLKDIV_PHASE_SYNC_EN
        .sync(sync),
`endif
        .en(en),
        .load(load),
        .load_ch(load_ch),
        .load_val(load_val),
        .sclk(sclk),
        .tick(tick),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int c = 0; c < NCH; c++) begin
            mdiv[c] = DDIV;
            rem[c]  = DDIV + 1;
        end
        msclk = '0;
        mtick = '0;
        merr  = 1'b0;
    endtask

    // Model tracks enabled cycles remaining until each channel's next toggle.
    task automatic model_edge();
        if (!reset) begin
            mreset();
            return;
        end
`ifdef CLKDIV_PHASE_SYNC_EN
        if (sync) begin
            for (int c = 0; c < NCH; c++) rem[c] = mdiv[c] + 1;
            msclk = '0;
            mtick = '0;
            merr  = 1'b0;
            return;
        end
`endif
        for (int c = 0; c < NCH; c++) begin
            mtick[c] = 1'b0;
            if (load && int'(load_ch) == c) begin
                mdiv[c] = longint'(load_val);
                rem[c]  = longint'(load_val) + 1;
            end else if (en[c]) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    msclk[c] = ~msclk[c];
                    mtick[c] = 1'b1;
                    rem[c]   = mdiv[c] + 1;
                end
            end
        end
        merr = load && int'(load_ch) >= NCH;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".sclk"}, 32'(sclk), 32'(msclk));
        chk({tag, ".tick"}, 32'(tick), 32'(mtick));
        chk({tag, ".load_err"}, 32'(load_err), 32'(merr));
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    initial begin
        reset = 1'b0; en = '0; load = 1'b0; load_ch = '0; load_val = '0;
        mreset();
        #1;
        chk("rst_async.sclk", 32'(sclk), 32'h0);
        chk("rst_async.tick", 32'(tick), 32'h0);
        chk("rst_async.err", 32'(load_err), 32'h0);
        run("reset", 2);
        reset = 1'b1; en = 2'b11;
        run("free_run", 20);
        load = 1'b1; load_ch = 3'd1; load_val = 0;
        cycle("load_ch1");
        load = 1'b0;
        run("fast_ch1", 10);
        load = 1'b1; load_ch = 3'd5; load_val = 32'd9;
        cycle("bad_load");
        load = 1'b0;
        run("after_bad", 10);
        load = 1'b1; load_ch = 3'd1; load_val = 32'd3;
        cycle("reload_ch1");
        load = 1'b0;
        run("pre_gate", 2);
        en = 2'b10;
        run("gated", 10);
        en = 2'b11;
        run("resume", 12);
        load = 1'b1; load_ch = 3'd0; load_val = 32'd7;
        cycle("load_ch0");
        load = 1'b0;
        run("slow_ch0", 5);
        #2 reset = 1'b0;
        #1;
        chk("midrst.sclk", 32'(sclk), 32'h0);
        chk("midrst.tick", 32'(tick), 32'h0);
        chk("midrst.err", 32'(load_err), 32'h0);
        mreset();
        cycle("in_reset");
        reset = 1'b1;
        run("post_reset", 12);
`ifdef CLKDIV_PHASE_SYNC_EN
        en = 2'b01;
        run("skew", 3);
        en = 2'b11;
        sync = 1'b1;
        cycle("sync");
        chk("sync.sclk0", 32'(sclk), 32'h0);
        sync = 1'b0;
        run("aligned", 12);
`endif
        for (int k = 0; k < 300; k++) begin
            en       = NCH'($urandom_range(0, 3));
            load     = ($urandom_range(0, 7) == 0);
            load_ch  = 3'($urandom_range(0, 7));
            load_val = WIDTH'($urandom_range(0, 5));
`ifdef CLKDIV_PHASE_SYNC_EN
            sync     = ($urandom_range(0, 19) == 0);
`endif
            cycle("random");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
